// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: default parameters and FSM state encoding.
package reg_bank_arbiter_pkg;

   localparam int N_DEF         = 4;
   localparam int DEPTH_DEF     = 8;
   localparam int AW_DEF        = 3;
   localparam int W_DEF         = 8;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational rotating-priority search: the first set request after ptr wins.
module rr_pick
   import reg_bank_arbiter_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int PW = $clog2(N_DEF)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [PW-1:0] idx,
   output logic          valid
);

   logic [PW-1:0] pos_s;

   // walk ptr+1 .. ptr+N modulo N and keep only the first hit
   always_comb begin
      win   = '0;
      idx   = '0;
      valid = 1'b0;
      pos_s = '0;
      for (int k = 1; k <= N; k++) begin
         pos_s = PW'((int'(ptr) + k) % N);
         if (!valid && req[pos_s]) begin
            win[pos_s] = 1'b1;
            idx        = pos_s;
            valid      = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one write port of a flop register bank, with bounded locked bursts.
module reg_bank_arbiter
   import reg_bank_arbiter_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int AW        = AW_DEF,
   parameter int W         = W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    lock,
   input  logic [N*AW-1:0] wr_addr,
   input  logic [N*W-1:0]  wr_data,
   output logic [N-1:0]    gnt,
   output logic [N-1:0]    ack,
   output logic            busy,
   input  logic [AW-1:0]   rd_addr,
   output logic [W-1:0]    rd_data
);

   localparam int            PW         = $clog2(N);
   localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);
   localparam logic [3:0]    BURST_LAST = 4'(MAX_BURST - 1);
   localparam logic [PW-1:0] PTR_RST    = PW'(N - 1);

   state_e        state_r;
   logic [PW-1:0] ptr_r;
   logic [PW-1:0] idx_r;
   logic [3:0]    cnt_r;
   logic [W-1:0]  bank_r [DEPTH];

   logic [N-1:0]  win_s;
   logic [PW-1:0] win_idx_s;
   logic          win_valid_s;
   logic          sel_req_s;
   logic          sel_lock_s;
   logic [AW-1:0] sel_addr_s;
   logic [W-1:0]  sel_data_s;
   logic          addr_ok_s;
   logic          rd_ok_s;
   logic          wr_en_s;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_r),
      .win   (win_s),
      .idx   (win_idx_s),
      .valid (win_valid_s)
   );

   // only the granted requester's inputs are ever looked at
   always_comb begin
      sel_req_s  = req[idx_r];
      sel_lock_s = lock[idx_r];
      sel_addr_s = wr_addr[int'(idx_r)*AW +: AW];
      sel_data_s = wr_data[int'(idx_r)*W +: W];
      addr_ok_s  = ({1'b0, sel_addr_s} < DEPTH_L);
      rd_ok_s    = ({1'b0, rd_addr} < DEPTH_L);
      wr_en_s    = (state_r == GRANT) && sel_req_s && addr_ok_s;
   end

   // grant FSM: pointer, burst counter and registered grant/ack/busy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         ptr_r   <= PTR_RST;
         idx_r   <= '0;
         cnt_r   <= 4'd0;
         gnt     <= '0;
         ack     <= '0;
         busy    <= 1'b0;
      end else begin
         ack <= '0;
         case (state_r)
            IDLE: begin
               if (win_valid_s) begin
                  state_r <= GRANT;
                  idx_r   <= win_idx_s;
                  gnt     <= win_s;
                  busy    <= 1'b1;
                  cnt_r   <= 4'd0;
               end
            end
            GRANT: begin
               if (sel_req_s) begin
                  ack[idx_r] <= 1'b1;
                  cnt_r      <= cnt_r + 4'd1;
                  if (!sel_lock_s || (cnt_r == BURST_LAST)) begin
                     state_r <= IDLE;
                     gnt     <= '0;
                     busy    <= 1'b0;
                     ptr_r   <= idx_r;
                  end
               end else begin
                  // requester withdrew: release without writing
                  state_r <= IDLE;
                  gnt     <= '0;
                  busy    <= 1'b0;
                  ptr_r   <= idx_r;
               end
            end
            default: begin
               state_r <= IDLE;
               gnt     <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // storage and registered read port; a same-edge read sees the pre-write value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int e = 0; e < DEPTH; e++) begin
            bank_r[e] <= '0;
         end
         rd_data <= '0;
      end else begin
         if (wr_en_s) begin
            bank_r[sel_addr_s] <= sel_data_s;
         end
         rd_data <= rd_ok_s ? bank_r[rd_addr] : '0;
      end
   end

endmodule
